// File: rtl/uart_pkg.sv
// Shared constants for the UART io_core blocks.
package uart_pkg;

  // Byte width of the UART datapath.
  localparam int unsigned DATA_W = 8;

  // Divisor after reset: 100 MHz / (16 * 9600) - 1.
  localparam int unsigned DVSR_RST_DEFAULT = 650;

endpackage

// File: rtl/reg_fifo.sv
// Register-based synchronous FIFO with first-word fall-through read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module reg_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              push, pop;

  // Qualify requests: a pop on empty is ignored; a push on full is only
  // accepted when a pop frees a slot on the same edge.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    pop      = rd && !empty;
    push     = wr && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Storage is deliberately not reset; r_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= w_data;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Head of queue straight from storage: no path from rd to r_data.
  assign r_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: programmable baud tick generator, receive byte
// FIFO and sticky overrun flag for the processor-side register slot.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DVSR_W   = 11,
  parameter int unsigned DVSR_RST = DVSR_RST_DEFAULT,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dvsr_wr,
  input  logic [DVSR_W-1:0] dvsr_in,
  output logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [DATA_W-1:0] rx_dout,
  input  logic              rd_uart,
  output logic [DATA_W-1:0] r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [FIFO_AW:0]  rx_count,
  output logic              overrun,
  input  logic              clr_overrun
);

  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              drop;

  // Baud counter runs 0..dvsr; a divisor write restarts the period.
  always_comb begin
    s_tick = (cnt_q == dvsr_q);
    dvsr_d = dvsr_q;
    cnt_d  = s_tick ? '0 : cnt_q + 1'b1;
    if (dvsr_wr) begin
      dvsr_d = dvsr_in;
      cnt_d  = '0;
    end
  end

  // Byte lost only when full with no pop on the same edge; set beats clear.
  always_comb begin
    drop      = rx_done_tick && rx_full && !rd_uart;
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  // Baud generator and overrun state.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr_q    <= DVSR_W'(DVSR_RST);
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

  reg_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_done_tick),
    .w_data (rx_dout),
    .rd     (rd_uart),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full),
    .count  (rx_count)
  );

endmodule
